// File: rtl/spi_xfer_ctrl_if.sv
// Command descriptor, TX byte stream and SPI PHY/RX-assembler signals of the
// mode-0 SPI transfer sequencer. master = the sequencer, slave = its environment.
interface spi_xfer_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_tx_len;
  logic [CNT_W-1:0] cmd_rx_len;
  logic [7:0]       tx_data;
  logic             tx_vld;
  logic             tx_rdy;
  logic             phy_cs_n;
  logic             phy_sclk;
  logic             phy_mosi;
  logic             phy_start;
  logic             phy_finish;
  logic             phy_bit_vld;
  logic             busy;
  logic             done;

  modport master (
    input  cmd_valid, cmd_tx_len, cmd_rx_len, tx_data, tx_vld,
    output cmd_ready, tx_rdy, phy_cs_n, phy_sclk, phy_mosi,
           phy_start, phy_finish, phy_bit_vld, busy, done
  );

  modport slave (
    output cmd_valid, cmd_tx_len, cmd_rx_len, tx_data, tx_vld,
    input  cmd_ready, tx_rdy, phy_cs_n, phy_sclk, phy_mosi,
           phy_start, phy_finish, phy_bit_vld, busy, done
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master transaction sequencer: one command = TX bytes (MSB first)
// followed by RX bit clocking, with frame start/finish and per-bit sample strobes.
module spi_xfer_ctrl #(
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic            clock,
  input  logic            rst_n,
  spi_xfer_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_TX_LOAD,
    S_TX_BIT,
    S_RX_BIT,
    S_HOLD
  } state_e;

  localparam logic [7:0]       DIV_M1 = 8'(DIV - 1);
  localparam logic [CNT_W-1:0] TX_ONE = CNT_W'(1);
  localparam logic [CNT_W+2:0] RX_ONE = (CNT_W + 3)'(1);

  state_e           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] tx_left_q, tx_left_d;
  logic [CNT_W+2:0] rx_bits_q, rx_bits_d;
  logic [7:0]       shift_q, shift_d;

  logic cs_n_q, cs_n_d;
  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic start_q, start_d;
  logic finish_q, finish_d;
  logic bit_vld_q, bit_vld_d;
  logic done_q, done_d;
  logic busy_q, busy_d;
  logic cmd_ready_q, cmd_ready_d;
  logic tx_rdy_q, tx_rdy_d;

  logic div_tc;
  assign div_tc = (div_q == DIV_M1);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_left_d = tx_left_q;
    rx_bits_d = rx_bits_q;
    shift_d   = shift_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    tx_rdy_d  = tx_rdy_q;
    start_d   = 1'b0;
    finish_d  = 1'b0;
    bit_vld_d = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          tx_left_d = bus.cmd_tx_len;
          rx_bits_d = {bus.cmd_rx_len, 3'b000};
          if ((bus.cmd_tx_len == '0) && (bus.cmd_rx_len == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = S_SETUP;
            cs_n_d  = 1'b0;
            start_d = 1'b1;
            div_d   = '0;
          end
        end
      end

      S_SETUP: begin
        if (div_tc) begin
          div_d = '0;
          bit_d = '0;
          if (tx_left_q != '0) begin
            state_d  = S_TX_LOAD;
            tx_rdy_d = 1'b1;
          end else begin
            state_d = S_RX_BIT;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_TX_LOAD: begin
        if (bus.tx_vld) begin
          shift_d   = {bus.tx_data[6:0], 1'b0};
          mosi_d    = bus.tx_data[7];
          tx_left_d = tx_left_q - TX_ONE;
          tx_rdy_d  = 1'b0;
          div_d     = '0;
          bit_d     = '0;
          state_d   = S_TX_BIT;
        end
      end

      S_TX_BIT: begin
        if (div_tc) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // mosi only moves together with the registered sclk 1->0 transition
          if (sclk_q) begin
            if (bit_q == 3'd7) begin
              if (tx_left_q != '0) begin
                state_d  = S_TX_LOAD;
                tx_rdy_d = 1'b1;
              end else if (rx_bits_q != '0) begin
                state_d = S_RX_BIT;
                mosi_d  = 1'b0;
              end else begin
                state_d  = S_HOLD;
                finish_d = 1'b1;
                mosi_d   = 1'b0;
              end
            end else begin
              mosi_d  = shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
              bit_d   = bit_q + 3'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_RX_BIT: begin
        if (div_tc) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            bit_vld_d = 1'b1;
          end else begin
            rx_bits_d = rx_bits_q - RX_ONE;
            if (rx_bits_q == RX_ONE) begin
              state_d  = S_HOLD;
              finish_d = 1'b1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_HOLD: begin
        if (div_tc) begin
          div_d   = '0;
          state_d = S_IDLE;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        tx_rdy_d = 1'b0;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_left_q   <= '0;
      rx_bits_q   <= '0;
      shift_q     <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      start_q     <= 1'b0;
      finish_q    <= 1'b0;
      bit_vld_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      tx_rdy_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_left_q   <= tx_left_d;
      rx_bits_q   <= rx_bits_d;
      shift_q     <= shift_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      start_q     <= start_d;
      finish_q    <= finish_d;
      bit_vld_q   <= bit_vld_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      tx_rdy_q    <= tx_rdy_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.tx_rdy      = tx_rdy_q;
  assign bus.phy_cs_n    = cs_n_q;
  assign bus.phy_sclk    = sclk_q;
  assign bus.phy_mosi    = mosi_q;
  assign bus.phy_start   = start_q;
  assign bus.phy_finish  = finish_q;
  assign bus.phy_bit_vld = bit_vld_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  a_bit_vld_in_rx: assert property (@(posedge clock) disable iff (!rst_n)
    bit_vld_q |-> (state_q == S_RX_BIT) && sclk_q);
  a_tx_rdy_in_load: assert property (@(posedge clock) disable iff (!rst_n)
    tx_rdy_q |-> (state_q == S_TX_LOAD));
  a_start_finish_excl: assert property (@(posedge clock) disable iff (!rst_n)
    !(start_q && finish_q));

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: DUT a runs with DIV=2, DUT b with DIV=1.
module tb_spi_xfer_ctrl;
  localparam int CNT_W = 8;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  spi_xfer_ctrl_if #(.CNT_W(CNT_W)) ifa ();
  spi_xfer_ctrl_if #(.CNT_W(CNT_W)) ifb ();

  spi_xfer_ctrl #(.DIV(2), .CNT_W(CNT_W)) u_dut_a (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (ifa.master)
  );

  spi_xfer_ctrl #(.DIV(1), .CNT_W(CNT_W)) u_dut_b (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (ifb.master)
  );

  logic [1:0] sclk_w, cs_w, mosi_w, start_w, fin_w, bv_w, done_w, busy_w, txrdy_w, rdy_w;
  assign sclk_w  = {ifb.phy_sclk,    ifa.phy_sclk};
  assign cs_w    = {ifb.phy_cs_n,    ifa.phy_cs_n};
  assign mosi_w  = {ifb.phy_mosi,    ifa.phy_mosi};
  assign start_w = {ifb.phy_start,   ifa.phy_start};
  assign fin_w   = {ifb.phy_finish,  ifa.phy_finish};
  assign bv_w    = {ifb.phy_bit_vld, ifa.phy_bit_vld};
  assign done_w  = {ifb.done,        ifa.done};
  assign busy_w  = {ifb.busy,        ifa.busy};
  assign txrdy_w = {ifb.tx_rdy,      ifa.tx_rdy};
  assign rdy_w   = {ifb.cmd_ready,   ifa.cmd_ready};

  int n_checks = 0;
  int n_bad    = 0;

  // event monitor, sampled on the falling core-clock edge
  int cyc = 0;
  int rise_n[2], start_n[2], fin_n[2], bv_n[2], bv_bad_n[2], done_n[2], cs_tog_n[2], mosi_hi_n[2];
  int rise_first[2], rise_last[2], start_cyc[2], fin_cyc[2], bv_first[2], bv_last[2];
  logic [31:0] mosi_hist[2];
  logic [1:0]  psclk = 2'b00;
  logic [1:0]  pcs   = 2'b11;

  initial begin
    for (int unsigned d = 0; d < 2; d++) begin
      rise_n[d] = 0; start_n[d] = 0; fin_n[d] = 0; bv_n[d] = 0; bv_bad_n[d] = 0;
      done_n[d] = 0; cs_tog_n[d] = 0; mosi_hi_n[d] = 0; rise_first[d] = 0; rise_last[d] = 0;
      start_cyc[d] = 0; fin_cyc[d] = 0; bv_first[d] = 0; bv_last[d] = 0; mosi_hist[d] = '0;
    end
  end

  always @(negedge clock) begin
    cyc = cyc + 1;
    for (int unsigned d = 0; d < 2; d++) begin
      if (sclk_w[d] && !psclk[d]) begin
        rise_n[d]++;
        mosi_hist[d] = {mosi_hist[d][30:0], mosi_w[d]};
        if (rise_first[d] < start_cyc[d]) rise_first[d] = cyc;
        rise_last[d] = cyc;
      end
      if (bv_w[d]) begin
        bv_n[d]++;
        if (!(sclk_w[d] && !psclk[d])) bv_bad_n[d]++;
        if (bv_first[d] < start_cyc[d]) bv_first[d] = cyc;
        bv_last[d] = cyc;
      end
      if (start_w[d]) begin start_n[d]++; start_cyc[d] = cyc; end
      if (fin_w[d])   begin fin_n[d]++;   fin_cyc[d]   = cyc; end
      if (done_w[d])  done_n[d]++;
      if (cs_w[d] != pcs[d]) cs_tog_n[d]++;
      if (mosi_w[d]) mosi_hi_n[d]++;
      psclk[d] = sclk_w[d];
      pcs[d]   = cs_w[d];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic set_cmd(input int unsigned d, input logic v, input logic [7:0] tx, input logic [7:0] rx);
    if (d == 0) begin
      ifa.cmd_valid = v; ifa.cmd_tx_len = tx; ifa.cmd_rx_len = rx;
    end else begin
      ifb.cmd_valid = v; ifb.cmd_tx_len = tx; ifb.cmd_rx_len = rx;
    end
  endtask

  // returns one cycle after the handshake cycle, cmd_valid dropped
  task automatic issue(input int unsigned d, input logic [7:0] tx, input logic [7:0] rx, output int hs);
    int unsigned n = 0;
    while (!rdy_w[d] && n < 50) begin tick(); n++; end
    check("cmd_ready_at_issue", {31'd0, rdy_w[d]}, 32'd1);
    set_cmd(d, 1'b1, tx, rx);
    hs = cyc;
    tick();
    set_cmd(d, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic wait_done(input int unsigned d, input int unsigned limit, output int dcyc);
    int unsigned n = 0;
    while (!done_w[d] && n < limit) begin tick(); n++; end
    check("done_seen", {31'd0, done_w[d]}, 32'd1);
    dcyc = cyc;
  endtask

  int hs, dc, hs2, dc2;
  int r0, s0, f0, b0, d0, c0, m0, bb0;
  int stall_bad, ready_bad;
  int unsigned n;

  initial begin
    set_cmd(0, 1'b0, 8'd0, 8'd0);
    set_cmd(1, 1'b0, 8'd0, 8'd0);
    ifa.tx_data = 8'h00; ifa.tx_vld = 1'b0;
    ifb.tx_data = 8'h00; ifb.tx_vld = 1'b0;

    // reset values: {cs_n,sclk,mosi,start,finish,bit_vld,done,busy,tx_rdy,cmd_ready}
    #2 rst_n = 1'b0;
    tick();
    check("rst_a", {22'd0, cs_w[0], sclk_w[0], mosi_w[0], start_w[0], fin_w[0], bv_w[0],
                    done_w[0], busy_w[0], txrdy_w[0], rdy_w[0]}, 32'b10_0000_0001);
    check("rst_b", {22'd0, cs_w[1], sclk_w[1], mosi_w[1], start_w[1], fin_w[1], bv_w[1],
                    done_w[1], busy_w[1], txrdy_w[1], rdy_w[1]}, 32'b10_0000_0001);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // 1: DIV=2, one TX byte 0xA5, no RX
    ifa.tx_data = 8'hA5; ifa.tx_vld = 1'b1;
    r0 = rise_n[0]; s0 = start_n[0]; f0 = fin_n[0]; b0 = bv_n[0];
    issue(0, 8'd1, 8'd0, hs);
    wait_done(0, 200, dc);
    check("t1_latency", dc - hs, 38);
    check("t1_cs_at_done", {31'd0, cs_w[0]}, 32'd1);
    check("t1_rises", rise_n[0] - r0, 8);
    check("t1_mosi", {24'd0, mosi_hist[0][7:0]}, 32'hA5);
    check("t1_first_rise", rise_first[0] - hs, 6);
    check("t1_rise_span", rise_last[0] - rise_first[0], 28);
    check("t1_start", start_n[0] - s0, 1);
    check("t1_finish", fin_n[0] - f0, 1);
    check("t1_bit_vld", bv_n[0] - b0, 0);
    ifa.tx_vld = 1'b0;
    tick();

    // 2: DIV=1, RX only, two bytes
    b0 = bv_n[1]; bb0 = bv_bad_n[1]; m0 = mosi_hi_n[1]; s0 = start_n[1]; f0 = fin_n[1];
    issue(1, 8'd0, 8'd2, hs);
    wait_done(1, 200, dc);
    check("t2_latency", dc - hs, 35);
    check("t2_bit_vld", bv_n[1] - b0, 16);
    check("t2_bv_not_on_rise", bv_bad_n[1] - bb0, 0);
    check("t2_mosi_high", mosi_hi_n[1] - m0, 0);
    check("t2_start_n", start_n[1] - s0, 1);
    check("t2_finish_n", fin_n[1] - f0, 1);
    check("t2_start_cyc", start_cyc[1] - hs, 1);
    check("t2_first_bv", bv_first[1] - hs, 3);
    check("t2_last_bv", bv_last[1] - hs, 33);
    check("t2_finish_cyc", fin_cyc[1] - hs, 34);
    tick();

    // 3: DIV=2, two TX bytes with a 10-cycle stall before the second, one RX byte
    ifa.tx_data = 8'h3C; ifa.tx_vld = 1'b1;
    r0 = rise_n[0]; b0 = bv_n[0];
    issue(0, 8'd2, 8'd1, hs);
    n = 0;
    while (!txrdy_w[0] && n < 100) begin tick(); n++; end
    check("t3_tx_rdy_byte0", {31'd0, txrdy_w[0]}, 32'd1);
    tick();
    ifa.tx_vld = 1'b0; ifa.tx_data = 8'hC3;
    n = 0;
    while (!txrdy_w[0] && n < 100) begin tick(); n++; end
    check("t3_tx_rdy_byte1", {31'd0, txrdy_w[0]}, 32'd1);
    stall_bad = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (sclk_w[0] !== 1'b0 || cs_w[0] !== 1'b0 || txrdy_w[0] !== 1'b1) stall_bad++;
      tick();
    end
    ifa.tx_vld = 1'b1;
    tick();
    ifa.tx_vld = 1'b0;
    wait_done(0, 300, dc);
    check("t3_stall_outputs", stall_bad, 0);
    check("t3_latency", dc - hs, 113);
    check("t3_rises", rise_n[0] - r0, 24);
    check("t3_bit_vld", bv_n[0] - b0, 8);
    check("t3_mosi", {8'd0, mosi_hist[0][23:0]}, 32'h003CC300);
    tick();

    // 4: DIV=1, empty command
    c0 = cs_tog_n[1]; r0 = rise_n[1]; s0 = start_n[1]; f0 = fin_n[1];
    issue(1, 8'd0, 8'd0, hs);
    wait_done(1, 10, dc);
    check("t4_latency", dc - hs, 1);
    tick();
    tick();
    check("t4_cs_toggles", cs_tog_n[1] - c0, 0);
    check("t4_sclk_rises", rise_n[1] - r0, 0);
    check("t4_start", start_n[1] - s0, 0);
    check("t4_finish", fin_n[1] - f0, 0);

    // 5: DIV=2, reset asserted during RX, then a fresh command
    ifa.tx_data = 8'h81; ifa.tx_vld = 1'b1;
    d0 = done_n[0]; f0 = fin_n[0]; b0 = bv_n[0];
    issue(0, 8'd1, 8'd4, hs);
    n = 0;
    while ((bv_n[0] - b0) < 10 && n < 500) begin tick(); n++; end
    check("t5_sclk_before_rst", {31'd0, sclk_w[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_async_rst", {28'd0, cs_w[0], sclk_w[0], busy_w[0], rdy_w[0]}, 32'b1001);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_no_done", done_n[0] - d0, 0);
    check("t5_no_finish", fin_n[0] - f0, 0);
    s0 = start_n[0]; f0 = fin_n[0];
    issue(0, 8'd1, 8'd0, hs);
    wait_done(0, 200, dc);
    check("t5_new_latency", dc - hs, 38);
    check("t5_new_start", start_n[0] - s0, 1);
    check("t5_new_finish", fin_n[0] - f0, 1);
    check("t5_new_mosi", {24'd0, mosi_hist[0][7:0]}, 32'h81);
    ifa.tx_vld = 1'b0;
    tick();

    // 6: DIV=1, back-to-back commands with cmd_valid held
    check("t6_ready_idle", {31'd0, rdy_w[1]}, 32'd1);
    set_cmd(1, 1'b1, 8'd0, 8'd1);
    hs = cyc;
    tick();
    ready_bad = 0;
    n = 0;
    while (!done_w[1] && n < 100) begin
      if (rdy_w[1]) ready_bad++;
      tick();
      n++;
    end
    check("t6_done1", {31'd0, done_w[1]}, 32'd1);
    check("t6_latency1", cyc - hs, 19);
    check("t6_ready_while_busy", ready_bad, 0);
    check("t6_ready_at_done", {31'd0, rdy_w[1]}, 32'd1);
    check("t6_cs_high_gap", {31'd0, cs_w[1]}, 32'd1);
    hs2 = cyc;
    tick();
    set_cmd(1, 1'b0, 8'd0, 8'd0);
    check("t6_second_start", {30'd0, cs_w[1], start_w[1]}, 32'b01);
    wait_done(1, 100, dc2);
    check("t6_latency2", dc2 - hs2, 19);

    tick();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
